// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words from a header-framed stream,
// writes them to instruction memory, then releases the CPU. Optional LOADER_CHECKSUM_EN adds an XOR trailer check.
module program_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DATA_W-1:0] w_instruction,
  output logic [ADDR_W-1:0] w_adr,
  output logic              w_enable,
  output logic              cpu_en,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, WRITE, RUN, ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  logic [15:0] n_words;
  logic [1:0]  idx;
  logic [23:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  logic [15:0] hdr_n;
  logic [15:0] next_count;

  always_comb begin
    accept     = byte_valid && byte_ready;
    hdr_n      = {byte_in, n_words[7:0]};
    next_count = words_loaded + 16'd1;
  end

  // Single FSM; byte_ready is always written together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      byte_ready    <= 1'b0;
      w_instruction <= '0;
      w_adr         <= '0;
      w_enable      <= 1'b0;
      cpu_en        <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      words_loaded  <= '0;
      n_words       <= '0;
      idx           <= '0;
      asm_word      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      w_enable <= 1'b0;
      if (start) begin
        // start beats any byte accepted this cycle and drops the CPU clock immediately
        state        <= HDR0;
        byte_ready   <= 1'b1;
        cpu_en       <= 1'b0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
        idx          <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else begin
        case (state)
          IDLE: byte_ready <= 1'b0;
          HDR0: if (accept) begin
            n_words[7:0] <= byte_in;
            state        <= HDR1;
          end
          HDR1: if (accept) begin
            n_words[15:8] <= byte_in;
            if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_N) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
          DATA: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            idx <= idx + 2'd1;
            case (idx)
              2'd0: asm_word[7:0]   <= byte_in;
              2'd1: asm_word[15:8]  <= byte_in;
              2'd2: asm_word[23:16] <= byte_in;
              default: begin
                w_instruction <= DATA_W'({byte_in, asm_word});
                w_adr         <= ADDR_W'(BASE_ADDR) + ADDR_W'(words_loaded);
                w_enable      <= 1'b1;
                state         <= WRITE;
                byte_ready    <= 1'b0;
              end
            endcase
          end
          WRITE: begin
            words_loaded <= next_count;
            if (next_count == n_words) begin
`ifdef LOADER_CHECKSUM_EN
              state      <= CHK;
              byte_ready <= 1'b1;
`else
              state      <= RUN;
              byte_ready <= 1'b0;
              cpu_en     <= 1'b1;
              load_done  <= 1'b1;
`endif
            end else begin
              state      <= DATA;
              byte_ready <= 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: if (accept) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state     <= RUN;
              cpu_en    <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
`endif
          RUN:   byte_ready <= 1'b0;
          ERROR: byte_ready <= 1'b0;
          default: begin
            state      <= IDLE;
            byte_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header framing, word assembly, errors, reload, reset abort.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] w_instruction;
  logic [10:0] w_adr;
  logic        w_enable;
  logic        cpu_en;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .w_instruction(w_instruction), .w_adr(w_adr), .w_enable(w_enable),
    .cpu_en(cpu_en), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int viol     = 0;
  logic [10:0] wr_adr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] words_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write; byte_ready must never be high during a write cycle.
  always @(negedge clk) begin
    if (w_enable) begin
      wr_adr.push_back(w_adr);
      wr_data.push_back(w_instruction);
      wr_cyc.push_back(cyc);
      if (byte_ready) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_adr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the byte has transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("byte_timeout", 32'd1, 32'd0);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic load_image(input int max_gap);
    logic [7:0] x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(words_q.size());
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    foreach (words_q[w]) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] wv;
        logic [7:0]  b;
        wv = words_q[w];
        b  = wv[8*k +: 8];
        x  = x ^ b;
        send_byte(b, (max_gap > 0) ? int'($urandom_range(max_gap)) : 0);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, 0);
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({pfx, "_w_enable"}, 32'(w_enable), 32'd0);
    check({pfx, "_w_adr"}, 32'(w_adr), 32'd0);
    check({pfx, "_w_instruction"}, w_instruction, 32'd0);
    check({pfx, "_cpu_en"}, 32'(cpu_en), 32'd0);
    check({pfx, "_load_done"}, 32'(load_done), 32'd0);
    check({pfx, "_load_error"}, 32'(load_error), 32'd0);
    check({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word load, valid held high
    clear_log();
    pulse_start();
    words_q = '{32'h12345678, 32'hDEADBEEF};
    load_image(0);
    check("basic_nwr", 32'(wr_adr.size()), 32'd2);
    check("basic_adr0", 32'(wr_adr[0]), 32'd0);
    check("basic_dat0", wr_data[0], 32'h12345678);
    check("basic_adr1", 32'(wr_adr[1]), 32'd1);
    check("basic_dat1", wr_data[1], 32'hDEADBEEF);
    check("basic_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
    check("basic_cpu_en", 32'(cpu_en), 32'd1);
    check("basic_done", 32'(load_done), 32'd1);
    check("basic_words", 32'(words_loaded), 32'd2);

    // Header N=0 and N=2049 both fail without writing
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    check("n0_error", 32'(load_error), 32'd1);
    check("n0_cpu_en", 32'(cpu_en), 32'd0);
    check("n0_ready", 32'(byte_ready), 32'd0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    repeat (2) @(negedge clk);
    check("nbig_error", 32'(load_error), 32'd1);
    check("nbig_cpu_en", 32'(cpu_en), 32'd0);
    check("err_nwr", 32'(wr_adr.size()), 32'd0);
    pulse_start();
    words_q = '{32'h44332211};
    load_image(0);
    check("recover_error", 32'(load_error), 32'd0);
    check("recover_done", 32'(load_done), 32'd1);
    check("recover_dat", wr_data[0], 32'h44332211);

    // Three words with random valid gaps
    clear_log();
    viol = 0;
    pulse_start();
    words_q = '{32'hA1B2C3D4, 32'h00FF00FF, 32'hCAFEF00D};
    load_image(3);
    check("gap_nwr", 32'(wr_adr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("gap_adr%0d", i), 32'(wr_adr[i]), 32'(i));
      check($sformatf("gap_dat%0d", i), wr_data[i], words_q[i]);
    end
    check("gap_ready_in_write", 32'(viol), 32'd0);
    check("gap_words", 32'(words_loaded), 32'd3);

`ifndef LOADER_CHECKSUM_EN
    // A stray byte in RUN is never accepted
    byte_in = 8'h55; byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("run_no_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
`endif

    // Reload from RUN
    clear_log();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("reload_cpu_drop", 32'(cpu_en), 32'd0);
    check("reload_words_clr", 32'(words_loaded), 32'd0);
    words_q = '{32'hDDCCBBAA};
    load_image(0);
    check("reload_nwr", 32'(wr_adr.size()), 32'd1);
    check("reload_adr", 32'(wr_adr[0]), 32'd0);
    check("reload_dat", wr_data[0], 32'hDDCCBBAA);
    check("reload_cpu_en", 32'(cpu_en), 32'd1);

    // Reset mid-word, then a clean load with no stale bytes
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    clear_log();
    pulse_start();
    words_q = '{32'h04030201};
    load_image(0);
    check("midrst_dat", wr_data[0], 32'h04030201);
    check("midrst_done", 32'(load_done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good and bad trailers
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0F, 0);
    repeat (2) @(negedge clk);
    check("csum_ok_done", 32'(load_done), 32'd1);
    check("csum_ok_cpu", 32'(cpu_en), 32'd1);
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0E, 0);
    repeat (2) @(negedge clk);
    check("csum_bad_error", 32'(load_error), 32'd1);
    check("csum_bad_cpu", 32'(cpu_en), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
